// File: rtl/uart_pkg.sv
// Shared UART encodings and receive state type.
// Used by both the receiver and the transmitter control block.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic [1:0] STOP_1 = 2'b00;
    localparam logic [1:0] STOP_2 = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
// Resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [1:0] ff_q;
    logic [1:0] ff_d;

    always_comb begin
        ff_d = {ff_q[0], d};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ff_q <= 2'b11;
        end else begin
            ff_q <= ff_d;
        end
    end

    assign q = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with valid/ready output register.
// Bits are sampled mid-bit, counted in bclk ticks only.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SAMPLING   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bclk,
    input  logic [1:0]            parity_select,
    input  logic [1:0]            stop_select,
    input  logic                  s_data_in,
    output logic [DATA_WIDTH-1:0] p_data_out,
    output logic                  valid,
    input  logic                  ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int CW = $clog2(SAMPLING);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] HALF = CW'(SAMPLING / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(SAMPLING - 1);
    localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);

    logic rxs;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (s_data_in),
        .q     (rxs)
    );

    rx_state_e             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  acc_q, acc_d;
    logic [1:0]            par_q, par_d;
    logic [1:0]            stop_q, stop_d;
    logic                  sidx_q, sidx_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  armed_q, armed_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  perr_o_q, perr_o_d;
    logic                  ferr_o_q, ferr_o_d;
    logic                  ovr_q, ovr_d;
    logic                  sample;
    logic                  done;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        par_d   = par_q;
        stop_d  = stop_q;
        sidx_d  = sidx_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        armed_d = armed_q;
        done    = 1'b0;
        sample  = bclk && (cnt_q == ((state_q == START) ? HALF : FULL));

        if (bclk && state_q != IDLE) begin
            cnt_d = sample ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                armed_d = armed_q | rxs;
                if (bclk && armed_q && !rxs) begin
                    state_d = START;
                    cnt_d   = '0;
                    bit_d   = '0;
                    acc_d   = 1'b0;
                    sidx_d  = 1'b0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    armed_d = 1'b0;
                    par_d   = (parity_select == 2'b11) ? PAR_NONE : parity_select;
                    stop_d  = (stop_select == STOP_2) ? STOP_2 : STOP_1;
                end
            end
            START: begin
                if (sample) begin
                    state_d = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample) begin
                    shift_d = {rxs, shift_q[DATA_WIDTH-1:1]};
                    acc_d   = acc_q ^ rxs;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LAST) begin
                        state_d = (par_q != PAR_NONE) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (sample) begin
                    perr_d  = (acc_q ^ rxs) != (par_q == PAR_ODD);
                    state_d = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    if (!rxs) begin
                        ferr_d = 1'b1;
                    end
                    if (stop_q == STOP_2 && !sidx_q) begin
                        sidx_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        done    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A completing frame wins over a plain acceptance in the same clk.
    always_comb begin
        dout_d   = dout_q;
        valid_d  = valid_q;
        perr_o_d = perr_o_q;
        ferr_o_d = ferr_o_q;
        ovr_d    = 1'b0;
        if (done) begin
            if (!valid_q || ready) begin
                dout_d   = shift_q;
                perr_o_d = perr_q;
                ferr_o_d = ferr_d;
                valid_d  = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            acc_q    <= 1'b0;
            par_q    <= PAR_NONE;
            stop_q   <= STOP_1;
            sidx_q   <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            armed_q  <= 1'b0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            perr_o_q <= 1'b0;
            ferr_o_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            acc_q    <= acc_d;
            par_q    <= par_d;
            stop_q   <= stop_d;
            sidx_q   <= sidx_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            armed_q  <= armed_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            perr_o_q <= perr_o_d;
            ferr_o_q <= ferr_o_d;
            ovr_q    <= ovr_d;
        end
    end

    assign p_data_out = dout_q;
    assign valid      = valid_q;
    assign parity_err = perr_o_q;
    assign frame_err  = ferr_o_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 16x oversampling, bclk every 4 clks.
// Words are captured by a monitor just after each rising clk edge.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bclk = 1'b0;
    logic [1:0] parity_select = 2'b00;
    logic [1:0] stop_select = 2'b00;
    logic       s_data_in = 1'b1;
    logic [7:0] p_data_out;
    logic       valid;
    logic       ready = 1'b1;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int errors = 0;
    int checks = 0;

    uart_rx #(.DATA_WIDTH(8), .SAMPLING(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .bclk          (bclk),
        .parity_select (parity_select),
        .stop_select   (stop_select),
        .s_data_in     (s_data_in),
        .p_data_out    (p_data_out),
        .valid         (valid),
        .ready         (ready),
        .parity_err    (parity_err),
        .frame_err     (frame_err),
        .overrun       (overrun),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int div = 0;
    always @(negedge clk) begin
        div = (div == 3) ? 0 : div + 1;
        bclk = (div == 0);
    end

    logic [7:0] got_data[$];
    bit         got_perr[$];
    bit         got_ferr[$];
    bit         got_tick[$];
    bit         got_busy[$];
    int         ovr_cnt = 0;
    int         vcyc = 0;
    logic       v_before = 1'b0;

    // A new word is visible when valid rises or is reloaded on acceptance.
    always @(posedge clk) begin
        #1;
        if (valid === 1'b1 && (v_before !== 1'b1 || ready === 1'b1)) begin
            got_data.push_back(p_data_out);
            got_perr.push_back(parity_err);
            got_ferr.push_back(frame_err);
            got_tick.push_back(bclk);
            got_busy.push_back(busy);
        end
        if (valid === 1'b1) vcyc++;
        if (overrun === 1'b1) ovr_cnt++;
        v_before = valid;
    end

    task automatic line_bit(input logic b);
        s_data_in = b;
        repeat (64) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit has_par,
                              input logic pbit, input bit two_stop,
                              input logic s2);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(d[i]);
        if (has_par) line_bit(pbit);
        line_bit(1'b1);
        if (two_stop) line_bit(s2);
        s_data_in = 1'b1;
    endtask

    task automatic wait_words(input int n, input string name);
        int k = 0;
        while (got_data.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (got_data.size() < n) begin
            errors++;
            $display("FAIL %s: timeout, words=%0d required %0d", name, got_data.size(), n);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        @(negedge clk);
        checks++; if (p_data_out !== 8'h00) begin errors++; $display("FAIL rst_data: got %h required 00", p_data_out); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", valid); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL rst_perr: got %b required 0", parity_err); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_ferr: got %b required 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_ovr: got %b required 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
        @(negedge clk);
        reset = 1'b1;
        line_bit(1'b1);
        line_bit(1'b1);
    endtask

    task automatic test_basic();
        int base = got_data.size();
        int v0 = vcyc;
        send_frame(8'hA5, 0, 1'b0, 0, 1'b1);
        wait_words(base + 1, "basic_wait");
        line_bit(1'b1);
        checks++; if (got_data[base] !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h required a5", got_data[base]); end
        checks++; if (got_perr[base] !== 1'b0) begin errors++; $display("FAIL basic_perr: got %b required 0", got_perr[base]); end
        checks++; if (got_ferr[base] !== 1'b0) begin errors++; $display("FAIL basic_ferr: got %b required 0", got_ferr[base]); end
        checks++; if (got_tick[base] !== 1'b1) begin errors++; $display("FAIL basic_latency: bclk at load edge %b required 1", got_tick[base]); end
        checks++; if (got_busy[base] !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b required 0", got_busy[base]); end
        checks++; if (vcyc - v0 !== 1) begin errors++; $display("FAIL basic_pulse: valid cycles %0d required 1", vcyc - v0); end
        checks++; if (got_data.size() !== base + 1) begin errors++; $display("FAIL basic_count: got %0d required %0d", got_data.size(), base + 1); end
    endtask

    task automatic test_parity();
        int base = got_data.size();
        parity_select = 2'b01;
        send_frame(8'h3C, 1, 1'b1, 0, 1'b1);
        send_frame(8'h3C, 1, 1'b0, 0, 1'b1);
        parity_select = 2'b10;
        send_frame(8'h01, 1, 1'b0, 0, 1'b1);
        wait_words(base + 3, "parity_wait");
        checks++; if (got_data[base] !== 8'h3C) begin errors++; $display("FAIL par_even_data: got %h required 3c", got_data[base]); end
        checks++; if (got_perr[base] !== 1'b1) begin errors++; $display("FAIL par_even_bad: got %b required 1", got_perr[base]); end
        checks++; if (got_perr[base+1] !== 1'b0) begin errors++; $display("FAIL par_even_ok: got %b required 0", got_perr[base+1]); end
        checks++; if (got_data[base+2] !== 8'h01) begin errors++; $display("FAIL par_odd_data: got %h required 01", got_data[base+2]); end
        checks++; if (got_perr[base+2] !== 1'b0) begin errors++; $display("FAIL par_odd_ok: got %b required 0", got_perr[base+2]); end
        checks++; if (got_ferr[base+2] !== 1'b0) begin errors++; $display("FAIL par_odd_ferr: got %b required 0", got_ferr[base+2]); end
        parity_select = 2'b00;
        line_bit(1'b1);
    endtask

    task automatic test_two_stop();
        int base = got_data.size();
        stop_select = 2'b01;
        send_frame(8'h55, 0, 1'b0, 1, 1'b0);
        send_frame(8'h55, 0, 1'b0, 1, 1'b1);
        wait_words(base + 2, "stop2_wait");
        checks++; if (got_data[base] !== 8'h55) begin errors++; $display("FAIL stop2_data: got %h required 55", got_data[base]); end
        checks++; if (got_ferr[base] !== 1'b1) begin errors++; $display("FAIL stop2_ferr: got %b required 1", got_ferr[base]); end
        checks++; if (got_ferr[base+1] !== 1'b0) begin errors++; $display("FAIL stop2_ok: got %b required 0", got_ferr[base+1]); end
        line_bit(1'b1);
        base = got_data.size();
        s_data_in = 1'b0;
        repeat (33 * 64) @(negedge clk);
        checks++; if (got_data.size() !== base + 1) begin errors++; $display("FAIL break_count: got %0d required %0d", got_data.size(), base + 1); end
        checks++; if (got_data[base] !== 8'h00) begin errors++; $display("FAIL break_data: got %h required 00", got_data[base]); end
        checks++; if (got_ferr[base] !== 1'b1) begin errors++; $display("FAIL break_ferr: got %b required 1", got_ferr[base]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_busy: got %b required 0", busy); end
        line_bit(1'b1);
        repeat (4) line_bit(1'b1);
        checks++; if (got_data.size() !== base + 1) begin errors++; $display("FAIL break_after: got %0d required %0d", got_data.size(), base + 1); end
        stop_select = 2'b00;
    endtask

    task automatic test_glitch();
        int base = got_data.size();
        s_data_in = 1'b0;
        repeat (16) @(negedge clk);
        s_data_in = 1'b1;
        repeat (128) @(negedge clk);
        checks++; if (got_data.size() !== base) begin errors++; $display("FAIL glitch_word: got %0d required %0d", got_data.size(), base); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b required 0", busy); end
        send_frame(8'h81, 0, 1'b0, 0, 1'b1);
        wait_words(base + 1, "glitch_wait");
        checks++; if (got_data[base] !== 8'h81) begin errors++; $display("FAIL glitch_next: got %h required 81", got_data[base]); end
        line_bit(1'b1);
    endtask

    task automatic test_back_to_back();
        int base = got_data.size();
        int o0 = ovr_cnt;
        ready = 1'b0;
        send_frame(8'h11, 0, 1'b0, 0, 1'b1);
        wait_words(base + 1, "bp_wait");
        send_frame(8'h22, 0, 1'b0, 0, 1'b1);
        line_bit(1'b1);
        checks++; if (got_data.size() !== base + 1) begin errors++; $display("FAIL bp_count: got %0d required %0d", got_data.size(), base + 1); end
        checks++; if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL bp_overrun: pulses %0d required 1", ovr_cnt - o0); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b required 1", valid); end
        checks++; if (p_data_out !== 8'h11) begin errors++; $display("FAIL bp_held: got %h required 11", p_data_out); end
        ready = 1'b1;
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bp_accept: got %b required 0", valid); end
        line_bit(1'b1);
        base = got_data.size();
        send_frame(8'h12, 0, 1'b0, 0, 1'b1);
        send_frame(8'h34, 0, 1'b0, 0, 1'b1);
        wait_words(base + 2, "b2b_wait");
        checks++; if (got_data[base] !== 8'h12) begin errors++; $display("FAIL b2b_first: got %h required 12", got_data[base]); end
        checks++; if (got_data[base+1] !== 8'h34) begin errors++; $display("FAIL b2b_second: got %h required 34", got_data[base+1]); end
        line_bit(1'b1);
    endtask

    task automatic test_reset_mid();
        int base;
        ready = 1'b0;
        send_frame(8'h5A, 0, 1'b0, 0, 1'b1);
        line_bit(1'b1);
        checks++; if (p_data_out !== 8'h5A) begin errors++; $display("FAIL rmid_held: got %h required 5a", p_data_out); end
        line_bit(1'b0);
        line_bit(1'b0);
        line_bit(1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_pre: got %b required 1", busy); end
        reset = 1'b0;
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b required 0", valid); end
        checks++; if (p_data_out !== 8'h00) begin errors++; $display("FAIL rmid_data: got %h required 00", p_data_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b required 0", busy); end
        s_data_in = 1'b1;
        ready = 1'b1;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        line_bit(1'b1);
        line_bit(1'b1);
        base = got_data.size();
        send_frame(8'h0F, 0, 1'b0, 0, 1'b1);
        wait_words(base + 1, "rmid_wait");
        checks++; if (got_data[base] !== 8'h0F) begin errors++; $display("FAIL rmid_next: got %h required 0f", got_data[base]); end
        checks++; if (got_ferr[base] !== 1'b0) begin errors++; $display("FAIL rmid_ferr: got %b required 0", got_ferr[base]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_two_stop();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
